mux2_rr_arbiter: RTL

- Shares one 2:1 output path between requesters A and B.
- Round-robin arbitration with bounded bursts and a ready/valid handshake on the output.
- Drives the select line of a 2:1 data mux, with sel=1 choosing A and sel=0 choosing B.
- Sits in front of any single-consumer resource that two producers contend for.

---
 rtl/mux2_arb_pkg.sv | 18 +
 rtl/mux2_rr_arbiter_if.sv | 29 ++
 rtl/burst_cnt.sv | 31 +++
 rtl/mux2_rr_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Burst counter width: at least one bit even when MAX_BURST is 1.
  function automatic int cnt_width(input int max_burst);
    return (max_burst < 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester, output-path and grant signals shared by the arbiter and its neighbours.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             out_ready;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             beat_a;
  logic             beat_b;

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, sel, out_data, out_valid, beat_a, beat_b
  );

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, sel, out_data, out_valid, beat_a, beat_b
  );

endinterface

// File: rtl/burst_cnt.sv
// Counts accepted beats within one grant; last flags the final beat allowed.
module burst_cnt
  import mux2_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] LAST_VAL = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 output path with bounded bursts.
//   state   | meaning
//   IDLE    | nobody owns the path, sel parked on B
//   GRANT_A | A owns the path, sel = 1
//   GRANT_B | B owns the path, sel = 0
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.slave bus
);

  import mux2_arb_pkg::*;

  state_t           state_q, state_d;
  logic             last_a_q, last_a_d;
  logic             cnt_clear, cnt_inc, cnt_last;
  logic             accept;
  logic [WIDTH-1:0] mux_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_a_q <= last_a_d;
    end
  end

  assign bus.gnt_a     = (state_q == GRANT_A);
  assign bus.gnt_b     = (state_q == GRANT_B);
  assign bus.sel       = (state_q == GRANT_A) ? SEL_A : SEL_B;
  assign bus.out_valid = (bus.gnt_a & bus.req_a) | (bus.gnt_b & bus.req_b);
  assign accept        = bus.out_valid & bus.out_ready;
  assign bus.beat_a    = accept & bus.gnt_a;
  assign bus.beat_b    = accept & bus.gnt_b;

  assign mux_data     = (bus.sel == SEL_A) ? bus.data_a : bus.data_b;
  assign bus.out_data = mux_data;

  always_comb begin
    state_d   = state_q;
    last_a_d  = last_a_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        // last_a_q low means B went last, so A takes a tie.
        if (bus.req_a && (!bus.req_b || !last_a_q)) begin
          state_d = GRANT_A;
        end else if (bus.req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!bus.req_a || (accept && cnt_last)) begin
          last_a_d  = 1'b1;
          cnt_clear = 1'b1;
          if (bus.req_b) begin
            state_d = GRANT_B;
          end else if (bus.req_a) begin
            state_d = GRANT_A;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_inc = accept;
        end
      end
      GRANT_B: begin
        if (!bus.req_b || (accept && cnt_last)) begin
          last_a_d  = 1'b0;
          cnt_clear = 1'b1;
          if (bus.req_a) begin
            state_d = GRANT_A;
          end else if (bus.req_b) begin
            state_d = GRANT_B;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_inc = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  burst_cnt #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

endmodule
